// File: rtl/self_output_pkg.sv
// Shared types and tiling constants for the self-output tile scheduler.
// Build option: SELF_OUT_WDOG_EN adds a per-wait watchdog in self_output_sched.
package self_output_pkg;

  localparam int unsigned TOKENS = 32;
  localparam int unsigned EMBED  = 768;
  localparam int unsigned TILE_T = 32;
  localparam int unsigned TILE_N = 64;
  localparam int unsigned TILE_K = 64;

  localparam int unsigned KT = EMBED / TILE_K;
  localparam int unsigned NT = EMBED / TILE_N;
  localparam int unsigned TT = TOKENS / TILE_T;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_WT_A, S_RD_W, S_WT_W, S_MM, S_WT_MM,
    S_RD_R, S_WT_R, S_LN, S_WT_LN, S_WR, S_WT_WR, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    KIND_ATTN   = 2'd0,
    KIND_WEIGHT = 2'd1,
    KIND_RESID  = 2'd2,
    KIND_OUT    = 2'd3
  } desc_kind_e;

  // Byte offset of a tile from its tensor base; all tensors are int8 row-major.
  function automatic logic [63:0] tile_offset(desc_kind_e kind, logic [15:0] t,
                                              logic [15:0] n, logic [15:0] k);
    logic [63:0] row_off;
    row_off = 64'(t) * 64'(TILE_T * EMBED);
    case (kind)
      KIND_ATTN:   tile_offset = row_off + 64'(k) * 64'(TILE_K);
      KIND_WEIGHT: tile_offset = 64'(k) * 64'(TILE_K * EMBED) + 64'(n) * 64'(TILE_N);
      default:     tile_offset = row_off;
    endcase
  endfunction

endpackage

// File: rtl/self_output_sched_if.sv
// Descriptor, DMA and engine-control bundle between the scheduler and its engines.
interface self_output_sched_if;
  logic        desc_valid;
  logic        desc_ready;
  logic        desc_write;
  logic [1:0]  desc_kind;
  logic [63:0] desc_addr;
  logic [15:0] desc_rows;
  logic [15:0] desc_row_bytes;
  logic [31:0] desc_stride;
  logic        dma_done;
  logic        dma_err;
  logic        mm_start;
  logic        mm_first;
  logic        mm_last;
  logic [15:0] mm_col;
  logic        mm_done;
  logic        ln_start;
  logic        ln_done;

  modport master (
    output desc_valid, desc_write, desc_kind, desc_addr, desc_rows, desc_row_bytes,
           desc_stride, mm_start, mm_first, mm_last, mm_col, ln_start,
    input  desc_ready, dma_done, dma_err, mm_done, ln_done
  );

  modport slave (
    input  desc_valid, desc_write, desc_kind, desc_addr, desc_rows, desc_row_bytes,
           desc_stride, mm_start, mm_first, mm_last, mm_col, ln_start,
    output desc_ready, dma_done, dma_err, mm_done, ln_done
  );
endinterface

// File: rtl/self_output_addr_gen.sv
// Combinational descriptor field generation for one DMA transfer.
module self_output_addr_gen
  import self_output_pkg::*;
(
  input  desc_kind_e  kind_i,
  input  logic [15:0] t_i,
  input  logic [15:0] n_i,
  input  logic [15:0] k_i,
  input  logic [63:0] base_attn_i,
  input  logic [63:0] base_weight_i,
  input  logic [63:0] base_resid_i,
  input  logic [63:0] base_out_i,
  output logic [63:0] addr_o,
  output logic [15:0] rows_o,
  output logic [15:0] row_bytes_o,
  output logic [31:0] stride_o,
  output logic        write_o
);
  logic [63:0] base;

  always_comb begin
    base        = base_out_i;
    rows_o      = 16'(TILE_T);
    row_bytes_o = 16'(EMBED);
    write_o     = 1'b0;
    case (kind_i)
      KIND_ATTN: begin
        base        = base_attn_i;
        row_bytes_o = 16'(TILE_K);
      end
      KIND_WEIGHT: begin
        base        = base_weight_i;
        rows_o      = 16'(TILE_K);
        row_bytes_o = 16'(TILE_N);
      end
      KIND_RESID: base    = base_resid_i;
      default:    write_o = 1'b1;
    endcase
    addr_o = base + tile_offset(kind_i, t_i, n_i, k_i);
  end

  assign stride_o = 32'(EMBED);
endmodule

// File: rtl/self_output_sched.sv
// Tile scheduler for LayerNorm(attn_out x W_so + bias + residual).
// Build option: SELF_OUT_WDOG_EN adds a WDOG_CYCLES per-wait watchdog.
module self_output_sched
  import self_output_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 1000000
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] addr_attn_output,
  input  logic [63:0] addr_weight,
  input  logic [63:0] addr_residual,
  input  logic [63:0] addr_output,
  input  logic [31:0] requant_m_mm,
  input  logic [7:0]  requant_e_mm,
  input  logic [31:0] requant_m_ln,
  input  logic [7:0]  requant_e_ln,
  output logic        done,
  output logic        error,
  output logic        busy,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic        desc_write,
  output logic [1:0]  desc_kind,
  output logic [63:0] desc_addr,
  output logic [15:0] desc_rows,
  output logic [15:0] desc_row_bytes,
  output logic [31:0] desc_stride,
  input  logic        dma_done,
  input  logic        dma_err,
  output logic        mm_start,
  output logic        mm_first,
  output logic        mm_last,
  output logic [15:0] mm_col,
  input  logic        mm_done,
  output logic        ln_start,
  input  logic        ln_done,
  output logic [31:0] cfg_m_mm,
  output logic [7:0]  cfg_e_mm,
  output logic [31:0] cfg_m_ln,
  output logic [7:0]  cfg_e_ln
);
  localparam logic [15:0] K_LAST = 16'(KT - 1);
  localparam logic [15:0] N_LAST = 16'(NT - 1);
  localparam logic [15:0] T_LAST = 16'(TT - 1);

  state_e      state_q;
  logic [15:0] t_q, n_q, k_q;
  logic [63:0] base_attn_q, base_weight_q, base_resid_q, base_out_q;
  logic        done_q, error_q, busy_q;
  logic [31:0] cfg_m_mm_q, cfg_m_ln_q;
  logic [7:0]  cfg_e_mm_q, cfg_e_ln_q;
  logic        desc_valid_q, desc_write_q;
  desc_kind_e  desc_kind_q, cur_kind;
  logic [63:0] desc_addr_q, ag_addr;
  logic [15:0] desc_rows_q, desc_bytes_q, ag_rows, ag_bytes;
  logic [31:0] desc_stride_q, ag_stride;
  logic        ag_write;
  logic        mm_start_q, mm_first_q, mm_last_q, ln_start_q;
  logic [15:0] mm_col_q;
  logic        accept;
`ifdef SELF_OUT_WDOG_EN
  logic [31:0] wdog_q;
  logic        in_wait;
  assign in_wait = state_q inside {S_WT_A, S_WT_W, S_WT_MM, S_WT_R, S_WT_LN, S_WT_WR};
`endif

  assign accept = start && (state_q inside {S_IDLE, S_DONE, S_ERR});

  always_comb begin
    cur_kind = KIND_OUT;
    case (state_q)
      S_RD_A:  cur_kind = KIND_ATTN;
      S_RD_W:  cur_kind = KIND_WEIGHT;
      S_RD_R:  cur_kind = KIND_RESID;
      default: ;
    endcase
  end

  self_output_addr_gen u_addr_gen (
    .kind_i        (cur_kind),
    .t_i           (t_q),
    .n_i           (n_q),
    .k_i           (k_q),
    .base_attn_i   (base_attn_q),
    .base_weight_i (base_weight_q),
    .base_resid_i  (base_resid_q),
    .base_out_i    (base_out_q),
    .addr_o        (ag_addr),
    .rows_o        (ag_rows),
    .row_bytes_o   (ag_bytes),
    .stride_o      (ag_stride),
    .write_o       (ag_write)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      {t_q, n_q, k_q} <= '0;
      {base_attn_q, base_weight_q, base_resid_q, base_out_q} <= '0;
      {done_q, error_q, busy_q} <= '0;
      {cfg_m_mm_q, cfg_e_mm_q, cfg_m_ln_q, cfg_e_ln_q} <= '0;
      desc_valid_q  <= 1'b0;
      desc_write_q  <= 1'b0;
      desc_kind_q   <= KIND_ATTN;
      desc_addr_q   <= '0;
      desc_rows_q   <= '0;
      desc_bytes_q  <= '0;
      desc_stride_q <= '0;
      {mm_start_q, mm_first_q, mm_last_q, ln_start_q} <= '0;
      mm_col_q      <= '0;
`ifdef SELF_OUT_WDOG_EN
      wdog_q        <= '0;
`endif
    end else begin
      mm_start_q <= 1'b0;
      ln_start_q <= 1'b0;
`ifdef SELF_OUT_WDOG_EN
      // Waits always exit to a non-wait state, so clearing outside waits covers every state change.
      wdog_q <= in_wait ? wdog_q + 32'd1 : '0;
`endif
      if (accept) begin
        base_attn_q   <= addr_attn_output;
        base_weight_q <= addr_weight;
        base_resid_q  <= addr_residual;
        base_out_q    <= addr_output;
        cfg_m_mm_q    <= requant_m_mm;
        cfg_e_mm_q    <= requant_e_mm;
        cfg_m_ln_q    <= requant_m_ln;
        cfg_e_ln_q    <= requant_e_ln;
        {done_q, error_q, busy_q} <= 3'b001;
        {t_q, n_q, k_q} <= '0;
        desc_valid_q  <= 1'b0;
        state_q       <= S_RD_A;
      end else if (busy_q && (dma_err
`ifdef SELF_OUT_WDOG_EN
                              || (in_wait && wdog_q >= 32'(WDOG_CYCLES))
`endif
                             )) begin
        state_q      <= S_ERR;
        error_q      <= 1'b1;
        busy_q       <= 1'b0;
        desc_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_RD_A, S_RD_W, S_RD_R, S_WR: begin
            if (!desc_valid_q) begin
              desc_valid_q  <= 1'b1;
              desc_kind_q   <= cur_kind;
              desc_write_q  <= ag_write;
              desc_addr_q   <= ag_addr;
              desc_rows_q   <= ag_rows;
              desc_bytes_q  <= ag_bytes;
              desc_stride_q <= ag_stride;
            end else if (desc_ready) begin
              desc_valid_q <= 1'b0;
              case (state_q)
                S_RD_A:  state_q <= S_WT_A;
                S_RD_W:  state_q <= S_WT_W;
                S_RD_R:  state_q <= S_WT_R;
                default: state_q <= S_WT_WR;
              endcase
            end
          end
          S_WT_A: if (dma_done) state_q <= S_RD_W;
          S_WT_W: if (dma_done) state_q <= S_MM;
          S_MM: begin
            mm_start_q <= 1'b1;
            mm_first_q <= (k_q == '0);
            mm_last_q  <= (k_q == K_LAST);
            mm_col_q   <= n_q;
            state_q    <= S_WT_MM;
          end
          S_WT_MM: if (mm_done) begin
            if (k_q != K_LAST) begin
              k_q     <= k_q + 16'd1;
              state_q <= S_RD_A;
            end else begin
              k_q <= '0;
              if (n_q != N_LAST) begin
                n_q     <= n_q + 16'd1;
                state_q <= S_RD_A;
              end else begin
                n_q     <= '0;
                state_q <= S_RD_R;
              end
            end
          end
          S_WT_R: if (dma_done) state_q <= S_LN;
          S_LN: begin
            ln_start_q <= 1'b1;
            state_q    <= S_WT_LN;
          end
          S_WT_LN: if (ln_done) state_q <= S_WR;
          S_WT_WR: if (dma_done) begin
            if (t_q != T_LAST) begin
              t_q     <= t_q + 16'd1;
              state_q <= S_RD_A;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign done     = done_q;
  assign error    = error_q;
  assign busy     = busy_q;
  assign cfg_m_mm = cfg_m_mm_q;
  assign cfg_e_mm = cfg_e_mm_q;
  assign cfg_m_ln = cfg_m_ln_q;
  assign cfg_e_ln = cfg_e_ln_q;

  assign desc_valid     = desc_valid_q;
  assign desc_write     = desc_write_q;
  assign desc_kind      = desc_kind_q;
  assign desc_addr      = desc_addr_q;
  assign desc_rows      = desc_rows_q;
  assign desc_row_bytes = desc_bytes_q;
  assign desc_stride    = desc_stride_q;
  assign mm_start       = mm_start_q;
  assign mm_first       = mm_first_q;
  assign mm_last        = mm_last_q;
  assign mm_col         = mm_col_q;
  assign ln_start       = ln_start_q;
endmodule
